// File: rtl/regfile_wb_sched.sv
// Write-port scheduler and scoreboard for the 1W2R register file.
// Merges pipeline writeback with queued long-latency results and generates the issue stall.
module regfile_wb_sched #(
    parameter int AWIDTH       = 5,
    parameter int DWIDTH       = 32,
    parameter int QDEPTH       = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p_we,
    input  logic [AWIDTH-1:0] p_wa,
    input  logic [DWIDTH-1:0] p_wd,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [AWIDTH-1:0] s_wa,
    input  logic [DWIDTH-1:0] s_wd,
    input  logic              iss_valid,
    input  logic              iss_long,
    input  logic [AWIDTH-1:0] iss_rd,
    input  logic [AWIDTH-1:0] iss_ra1,
    input  logic [AWIDTH-1:0] iss_ra2,
    output logic              stall,
    output logic              wb_hold,
    output logic              rf_we,
    output logic [AWIDTH-1:0] rf_wa,
    output logic [DWIDTH-1:0] rf_wd,
    output logic              err
);

    localparam int PW = $clog2(QDEPTH);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam int NREG = 1 << AWIDTH;

    logic [AWIDTH-1:0] q_wa [QDEPTH];
    logic [DWIDTH-1:0] q_wd [QDEPTH];
    logic [PW:0]       wptr, rptr;
    logic [CW-1:0]     starve_cnt;
    logic [NREG-1:0]   busy;

    logic              empty, full, p_act, hold_i, drain, accept, enq, stall_i, busy_set;
    logic [AWIDTH-1:0] head_wa;
    logic [DWIDTH-1:0] head_wd;

    function automatic logic hz(input logic [AWIDTH-1:0] a, input logic [NREG-1:0] bsy,
                                input logic drn, input logic [AWIDTH-1:0] dwa);
        return (a != '0) && bsy[a] && !(drn && (dwa == a));
    endfunction

    always_comb begin
        empty    = (wptr == rptr);
        full     = (wptr[PW] != rptr[PW]) && (wptr[PW-1:0] == rptr[PW-1:0]);
        head_wa  = q_wa[rptr[PW-1:0]];
        head_wd  = q_wd[rptr[PW-1:0]];
        p_act    = p_we && (p_wa != '0);
        hold_i   = (starve_cnt == CW'(STARVE_LIMIT));
        // The starvation hold lets the FIFO steal the port even from a live primary write.
        drain    = !empty && (!p_act || hold_i);
        accept   = s_valid && (!full || drain);
        enq      = accept && (s_wa != '0);
        stall_i  = iss_valid && (hz(iss_ra1, busy, drain, head_wa) ||
                                 hz(iss_ra2, busy, drain, head_wa) ||
                                 hz(iss_rd,  busy, drain, head_wa));
        busy_set = iss_valid && iss_long && !stall_i && (iss_rd != '0);
    end

    // Outputs are gated so they read 0 for the whole time reset is asserted.
    always_comb begin
        s_ready = rst_n && (!full || drain);
        stall   = rst_n && stall_i;
        wb_hold = rst_n && hold_i;
        rf_we   = rst_n && (drain || p_act);
        rf_wa   = '0;
        rf_wd   = '0;
        if (rst_n && drain) begin
            rf_wa = head_wa;
            rf_wd = head_wd;
        end else if (rst_n && p_act) begin
            rf_wa = p_wa;
            rf_wd = p_wd;
        end
    end

    // NOTE: FIFO storage has no reset; the pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            q_wa[wptr[PW-1:0]] <= s_wa;
            q_wd[wptr[PW-1:0]] <= s_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            rptr       <= '0;
            starve_cnt <= '0;
            busy       <= '0;
            err        <= 1'b0;
        end else begin
            if (enq)
                wptr <= wptr + 1'b1;
            if (drain)
                rptr <= rptr + 1'b1;
            if (empty || drain)
                starve_cnt <= '0;
            else
                starve_cnt <= starve_cnt + CW'(1);
            // Set is applied after clear so a same-address set wins.
            if (drain)
                busy[head_wa] <= 1'b0;
            if (busy_set)
                busy[iss_rd] <= 1'b1;
            if (p_act && (hold_i || busy[p_wa]))
                err <= 1'b1;
        end
    end

endmodule
